// File: rtl/noc_bus_arbiter.sv
// noc_bus_arbiter: round-robin owner of the shared 8-bit NoC bus with beat limit and turnaround.
// Define ARB_TIMEOUT_EN to add the idle watchdog that revokes a silent owner.
module noc_bus_arbiter #(
  parameter int MAX_BEATS    = 36,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       bus_valid,
  input  logic       bus_ready,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       grant_active,
  output logic [8:0] beat_cnt,
  output logic       timeout_err
);
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_REL} state_t;
  state_t     r_state, w_next;
  logic [1:0] r_id, r_last, w_pick;
  logic [8:0] r_beat_cnt;
  logic       w_any, w_beat, w_drop, w_limit, w_to, w_release;
  assign w_any   = |req;
  assign w_beat  = bus_valid & bus_ready;
  assign w_drop  = ~req[r_id];
  assign w_limit = w_beat && (r_beat_cnt == 9'(MAX_BEATS - 1));
  assign w_release = w_drop | w_limit | w_to;
  // Scan starts just after the last owner, so the previous owner is checked last.
  always_comb begin
    w_pick = r_last;
    for (int k = 4; k >= 1; k--)
      if (req[r_last + 2'(k)]) w_pick = r_last + 2'(k);
  end
  always_ff @(posedge clk)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb
    w_next = (r_state == S_IDLE)  ? (w_any ? S_GRANT : S_IDLE) :
             (r_state == S_GRANT) ? (w_release ? S_REL : S_GRANT) : S_IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      r_id       <= 2'd0;
      r_last     <= 2'd3;
      r_beat_cnt <= 9'd0;
    end else if (r_state == S_IDLE && w_any) begin
      r_id       <= w_pick;
      r_last     <= w_pick;
      r_beat_cnt <= 9'd0;
    end else if (r_state == S_GRANT && w_beat) begin
      r_beat_cnt <= r_beat_cnt + 9'd1;
    end
`ifdef ARB_TIMEOUT_EN
  logic [4:0] r_idle;
  logic       r_to_err;
  assign w_to = !w_beat && (r_idle == 5'(IDLE_TIMEOUT - 1));
  always_ff @(posedge clk)
    if (rst) begin
      r_idle   <= 5'd0;
      r_to_err <= 1'b0;
    end else begin
      r_idle   <= (r_state != S_GRANT || w_beat) ? 5'd0 : r_idle + 5'd1;
      r_to_err <= (r_state == S_GRANT) && w_to && !w_drop;
    end
  assign timeout_err = r_to_err;
`else
  assign w_to = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_comb begin
    grant_active = (r_state == S_GRANT);
    grant        = grant_active ? (4'd1 << r_id) : 4'd0;
    grant_id     = r_id;
    beat_cnt     = r_beat_cnt;
  end
endmodule

// File: tb/tb_noc_bus_arbiter.sv
// tb_noc_bus_arbiter: directed and random checks of noc_bus_arbiter against a transaction-level model.
module tb_noc_bus_arbiter;
  localparam int MAX_BEATS = 36;
  localparam int IDLE_TIMEOUT = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, bus_valid = 1'b0, bus_ready = 1'b0;
  logic [3:0] req = 4'd0, grant;
  logic [1:0] grant_id;
  logic grant_active, timeout_err;
  logic [8:0] beat_cnt;
  int n_assert = 0, n_fail = 0;
  int m_owner, m_id, m_last, m_beats, m_idle;
  bit m_gap, m_err;

  noc_bus_arbiter #(.MAX_BEATS(MAX_BEATS), .IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .grant(grant), .grant_id(grant_id), .grant_active(grant_active),
    .beat_cnt(beat_cnt), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Owner / turnaround / round-robin bookkeeping, advanced once per clock edge.
  task automatic model_step();
    bit beat, drop, limit, to;
    if (rst) begin
      m_owner = -1; m_gap = 0; m_id = 0; m_last = 3; m_beats = 0; m_idle = 0; m_err = 0;
      return;
    end
    m_err = 0;
    if (m_owner >= 0) begin
      beat = bus_valid & bus_ready;
      if (beat) m_beats++;
      m_idle = beat ? 0 : m_idle + 1;
      drop  = !req[m_owner];
      limit = beat && m_beats == MAX_BEATS;
      to    = TO_EN && m_idle == IDLE_TIMEOUT;
      if (drop || limit || to) begin
        m_err = to && !drop;
        m_owner = -1;
        m_gap = 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (req != 4'd0) begin
      for (int k = 1; k <= 4 && m_owner < 0; k++)
        if (req[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
      m_id = m_owner; m_last = m_owner; m_beats = 0; m_idle = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("grant", grant, m_owner >= 0 ? (32'd1 << m_owner) : 32'd0);
    chk("grant_active", grant_active, m_owner >= 0);
    chk("grant_id", grant_id, m_id);
    chk("beat_cnt", beat_cnt, m_beats);
    chk("timeout_err", timeout_err, m_err);
    chk("onehot0", $onehot0(grant), 1);
  endtask

  task automatic wait_grant();
    int n = 0;
    while (!grant_active && n < 10) begin
      cycle();
      n++;
    end
    chk("wait_grant", grant_active, 1);
  endtask

  initial begin
    logic [3:0] t2_exp [3] = '{4'b0010, 4'b0100, 4'b0010};
    // 1: reset with all requesting, then ID 0 first
    rst = 1; req = 4'b1111;
    cycle(); chk("t1_rst_grant", grant, 4'b0000);
    cycle(); chk("t1_rst_grant", grant, 4'b0000);
    rst = 0;
    cycle(); chk("t1_first", grant, 4'b0001);
    req = 4'b0000;
    repeat (3) cycle();
    // 2: SHA/AES alternate, owner drops after 3 beats
    req = 4'b0110;
    for (int r = 0; r < 3; r++) begin
      wait_grant();
      chk("t2_order", grant, t2_exp[r]);
      bus_valid = 1; bus_ready = 1;
      repeat (3) cycle();
      bus_valid = 0;
      req = 4'b0110 & ~grant;
      cycle(); chk("t2_gap", grant, 4'b0000); chk("t2_beats", beat_cnt, 3);
      req = 4'b0110;
    end
    req = 4'b0000;
    repeat (3) cycle();
    // 3: forced release at the beat limit, then re-grant
    req = 4'b0001;
    wait_grant();
    bus_valid = 1; bus_ready = 1;
    repeat (MAX_BEATS - 1) cycle();
    chk("t3_held", grant, 4'b0001);
    cycle(); chk("t3_rel", grant, 4'b0000); chk("t3_cnt", beat_cnt, MAX_BEATS);
    cycle(); chk("t3_turn", grant, 4'b0000); chk("t3_hold", beat_cnt, MAX_BEATS);
    cycle(); chk("t3_regrant", grant, 4'b0001); chk("t3_clr", beat_cnt, 0);
    bus_valid = 0; bus_ready = 0; req = 4'b0000;
    repeat (3) cycle();
    // 4: request drop coincides with a beat
    req = 4'b0010;
    wait_grant();
    bus_valid = 1; bus_ready = 1;
    repeat (2) cycle();
    req = 4'b0000;
    cycle(); chk("t4_cnt", beat_cnt, 3); chk("t4_grant", grant, 4'b0000); chk("t4_err", timeout_err, 0);
    bus_valid = 0; bus_ready = 0;
    repeat (2) cycle();
    // 5: silent owner; revoked by watchdog only when enabled
    req = 4'b0100;
    wait_grant();
    repeat (IDLE_TIMEOUT - 1) cycle();
    chk("t5_held", grant, 4'b0100);
    cycle(); chk("t5_grant", grant, TO_EN ? 4'b0000 : 4'b0100); chk("t5_err", timeout_err, TO_EN);
    cycle(); chk("t5_err_pulse", timeout_err, 0);
    req = 4'b0000;
    repeat (3) cycle();
    // 6: reset mid-grant
    req = 4'b1111;
    wait_grant();
    bus_valid = 1; bus_ready = 1;
    repeat (10) cycle();
    chk("t6_cnt", beat_cnt, 10);
    rst = 1;
    cycle(); chk("t6_grant", grant, 4'b0000); chk("t6_cnt0", beat_cnt, 0); chk("t6_act", grant_active, 0);
    rst = 0;
    cycle(); chk("t6_id0", grant, 4'b0001);
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) req[$urandom_range(3)] ^= 1'b1;
      bus_valid = $urandom_range(3) != 0;
      bus_ready = $urandom_range(3) != 0;
      if ($urandom_range(9) == 0) begin bus_valid = 0; bus_ready = 0; end
      rst = $urandom_range(199) == 0;
      cycle();
    end
    rst = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
